// File: rtl/div_seq_param.sv
// div_seq_param: multi-cycle restoring divider, one quotient bit per clock,
// unsigned or two's-complement, with valid/ready handshakes and divide-by-zero flag.
module div_seq_param #(
   parameter int WIDTH  = 16,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] prem, q, dvs;
   logic             sa, sb;
   logic             neg_a, neg_b, ge;
   logic [WIDTH-1:0] mag_a, mag_b, rn, qn;
   logic [WIDTH:0]   sh;
   assign neg_a = SIGNED && dividend[WIDTH-1];
   assign neg_b = SIGNED && divisor[WIDTH-1];
   assign mag_a = neg_a ? -dividend : dividend;
   assign mag_b = neg_b ? -divisor : divisor;
   // remainder always fits WIDTH bits after the subtract, so only the compare needs the extra bit
   always_comb begin
      sh = {prem, q[WIDTH-1]};
      ge = sh >= {1'b0, dvs};
      rn = ge ? sh[WIDTH-1:0] - dvs : sh[WIDTH-1:0];
      qn = {q[WIDTH-2:0], ge};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         prem        <= '0;
         q           <= '0;
         dvs         <= '0;
         sa          <= 1'b0;
         sb          <= 1'b0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sa       <= neg_a;
               sb       <= neg_b;
               q        <= mag_a;
               dvs      <= mag_b;
               prem     <= '0;
               cnt      <= '0;
               in_ready <= 1'b0;
               busy     <= 1'b1;
               if (divisor == '0) begin
                  state       <= DONE;
                  out_valid   <= 1'b1;
                  quotient    <= '1;
                  remainder   <= dividend;
                  div_by_zero <= 1'b1;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               prem <= rn;
               q    <= qn;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state       <= DONE;
                  out_valid   <= 1'b1;
                  quotient    <= (sa ^ sb) ? -qn : qn;
                  remainder   <= sa ? -rn : rn;
                  div_by_zero <= 1'b0;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
